// File: rtl/wishbone_mem_arbiter_if.sv
// Bus bundle between the requesting masters and the shared single-port memory.
// The slave modport is the arbiter's view; the master modport drives requests and models the memory.
interface wishbone_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            m_req;
    logic [NUM_MASTERS-1:0]            m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]            m_ack;
    logic [DATA_WIDTH-1:0]             m_rdata;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              mem_we;
    logic [DATA_WIDTH-1:0]             mem_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, mem_rdata,
        output m_ack, m_rdata, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, mem_rdata,
        input  m_ack, m_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/wishbone_mem_arbiter.sv
// Round-robin arbiter sharing one registered-read, read-before-write memory among NUM_MASTERS.
// Each transaction walks IDLE -> ISSUE -> CAPTURE -> DONE, acking in DONE.
module wishbone_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    wishbone_mem_arbiter_if.slave         bus,
    output logic                          busy,
    output logic [IDX_WIDTH-1:0]          grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;

    state_e                   state_q, state_d;
    logic [IDX_WIDTH-1:0]     rr_last_q, rr_last_d;
    logic [IDX_WIDTH-1:0]     grant_id_q, grant_id_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     lat_we_q, lat_we_d;
    logic [NUM_MASTERS-1:0]   m_ack_q, m_ack_d;
    logic [DATA_WIDTH-1:0]    m_rdata_q, m_rdata_d;

    logic                     found;
    logic [IDX_WIDTH-1:0]     cand;
    logic [IDX_WIDTH-1:0]     winner;

    // Search starts just after the last winner so every requester is reached within N grants.
    always_comb begin
        // NOTE: every always_comb variable gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        cand   = '0;
        winner = rr_last_q;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_WIDTH'((32'(rr_last_q) + 32'(i)) % NUM_MASTERS);
            if (!found && bus.m_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_id_d  = grant_id_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_we_d    = lat_we_q;
        m_ack_d     = '0;
        m_rdata_d   = m_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (IDX_WIDTH'(i) == winner) begin
                            mem_addr_d  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            mem_wdata_d = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                            lat_we_d    = bus.m_we[i];
                        end
                    end
                    grant_id_d = winner;
                    rr_last_d  = winner;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                // Memory returns the pre-write contents here, so writes echo the old data.
                m_rdata_d           = bus.mem_rdata;
                m_ack_d[grant_id_q] = 1'b1;
                state_d             = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= IDX_WIDTH'(NUM_MASTERS - 1);
            grant_id_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_we_q    <= 1'b0;
            m_ack_q     <= '0;
            m_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_id_q  <= grant_id_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_we_q    <= lat_we_d;
            m_ack_q     <= m_ack_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

    // Write strobe gated by rst so an abort during ISSUE never reaches the memory.
    assign bus.mem_we    = (state_q == ISSUE) && lat_we_q && !rst;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.m_ack     = m_ack_q;
    assign bus.m_rdata   = m_rdata_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_id_q;
endmodule
